serial_fifo_ctrl: RTL and testbench
===================================

# serial_fifo_ctrl

Buffered serial-port controller between the CPU memory-stage serial accesses and the UART receiver/transmitter pair. It replaces direct register peeking with a receive FIFO, fed by receiver data-ready pulses, and a transmit FIFO, drained through a start/busy handshake. It exposes the CPU serial map: data register at offset 0x8 and status register at offset 0xC. It also drives a receive interrupt line into the CPU interrupt vector.

## Interface
- RX_AW, 4: log2 of receive FIFO depth (16 entries).
- TX_AW, 4: log2 of transmit FIFO depth (16 entries).
- clk  in  1  controller clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_ce  in  1  serial access select (level, may be held for several cycles).
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  4  register offset; only 0x8 and 0xC are decoded.
- bus_wdata  in  8  write byte.
- bus_rdata  out  32  read data (combinational from addr and FIFO head).
- rx_ready  in  1  receiver data-ready pulse (foreign clock).
- rx_data  in  8  receiver byte, valid while rx_ready is high.
- tx_busy  in  1  transmitter busy (foreign clock).
- tx_start  out  1  transmit request, held until acknowledged.
- tx_data  out  8  byte to transmit, stable while tx_start is high.
- rx_int  out  1  receive FIFO not empty (level interrupt).

## Operation
- **Access qualification.** An access takes effect only in the first cycle in which bus_ce=1 after a cycle with bus_ce=0. One push or pop happens per access, regardless of hold length.
- **Read 0x8.**
  - bus_rdata = {24'b0, RX head}.
  - The qualifying cycle pops the RX FIFO.
  - If the RX FIFO is empty, bus_rdata = 0 and no pop occurs.
- **Read 0xC.**
  - bus_rdata = {29'b0, rx_overrun, rx_not_empty, tx_not_full}.
  - The qualifying cycle clears rx_overrun.
- **Other reads.** Any other offset reads 0.
- **Write 0x8.**
  - Pushes bus_wdata into the TX FIFO.
  - If the TX FIFO is full, the write is dropped silently.
- **Other writes.** Writes to 0xC or any other offset have no effect.
- **RX capture.**
  - rx_ready is passed through a 2-flop synchronizer, then a rising-edge detector.
  - On the detected edge, rx_data is pushed; rx_data is sampled at the second sync stage.
  - Push while full: the byte is dropped and rx_overrun is set (sticky).
- **Simultaneous RX push and pop.**
  - Both are performed.
  - When full, pop-then-push: the count is unchanged and no overrun occurs.
  - When empty, the pop is ignored and the push proceeds.
- **Simultaneous TX push and pop.** Both are performed; the full check uses the pre-pop count, so a push is still dropped when full.
- **FIFO implementation.** Circular buffers with AW-bit pointers plus an (AW+1)-bit count. Pointers wrap modulo 2^AW.
- **TX state machine.** tx_busy is synchronized by 2 flops to busy_s.
  - IDLE: when the TX FIFO is not empty, load tx_data from the head, set tx_start=1, and go to START.
  - START: hold tx_start and tx_data. When busy_s=1, pop the TX FIFO, drop tx_start to 0, and go to WAIT.
  - WAIT: when busy_s=0, go to IDLE.
  - There is no timeout; the FSM waits indefinitely for busy.
- **Interrupt.** rx_int = rx_not_empty.

## Timing
- **Reset (rst_n=0).**
  - FIFOs are emptied and rx_overrun=0.
  - FSM goes to IDLE; sync flops are cleared.
  - tx_start=0, tx_data=0, rx_int=0, bus_rdata=0.
- **After reset release.** A status read returns 0x1.
- **Reset mid-operation.** Reset asserted mid-transfer discards all FIFO contents immediately and drops tx_start asynchronously.
- **RX latency.** A byte becomes visible (rx_not_empty=1, rx_int=1) 3 clk edges after rx_ready rises.
- **rx_ready pulse width.** Pulses must be at least 1 clk period wide. A pulse held high produces exactly one push.
- **TX write to start latency.** From a write to an empty FIFO with FSM in IDLE, tx_start rises 2 edges after the qualifying write edge: push, then IDLE→START.
- **TX acknowledge.** tx_start falls on the edge after busy_s=1, i.e. 3 edges after tx_busy rises.
- **Back-to-back bytes.** Minimum spacing between tx_start assertions is one busy period plus 4 cycles.
- **Read data.** bus_rdata is valid combinationally in the qualifying cycle. The pop updates the head on that edge; later held cycles show the next byte but cause no further pops.

## Test plan
- **Reset status.** Assert rst_n=0, release, read 0xC -> 0x00000001; tx_start=0, rx_int=0.
- **RX path.** Pulse rx_ready with rx_data=0x41, then 0x42 -> rx_int=1 after 3 cycles; read 0x8 twice -> 0x41, then 0x42; status then reads 0x1 and rx_int=0.
- **RX overrun.** Push 17 bytes 0x00–0x10 -> status reads 0x7; the next status read returns 0x3; 16 data reads return 0x00–0x0F; the 17th data read returns 0.
- **TX handshake.** Write 0x55 and 0xAA, and model the transmitter raising tx_busy 2 cycles after tx_start for 20 cycles:
  - tx_start/tx_data present 0x55 and stay held until busy is seen.
  - Then 0xAA is presented after busy falls.
  - The FIFO ends empty and status reads 0x1.
- **TX full.** With tx_busy held low and no acknowledge, write 17 bytes -> status bit0=0 after 16 pushes (the first byte is held in START, not yet popped); the 17th byte is never transmitted.
- **Access edge and reset abort.**
  - Hold bus_ce=1 on a 0x8 read for 4 cycles with 2 bytes queued -> exactly one pop.
  - Assert rst_n=0 while tx_start=1 -> tx_start=0 immediately, with FIFOs empty after release.

Source files
------------

// File: rtl/serial_fifo_ctrl.sv
// Buffered serial-port controller: RX FIFO fed by a synchronised data-ready edge,
// TX FIFO drained by a start/busy handshake, CPU map at 0x8 (data) and 0xC (status).
module serial_fifo_ctrl #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_ce,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        rx_int
);

    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [3:0] ADDR_DATA = 4'h8;
    localparam logic [3:0] ADDR_STAT = 4'hC;
    localparam logic [RX_AW:0]   RX_FULL    = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_FULL    = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_CNT_ONE = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [TX_AW:0]   TX_CNT_ONE = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW-1:0] RX_PTR_ONE = {{(RX_AW - 1){1'b0}}, 1'b1};
    localparam logic [TX_AW-1:0] TX_PTR_ONE = {{(TX_AW - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_t;

    logic             ce_d_r;
    logic             rx_sync1_r, rx_sync2_r, rx_prev_r;
    logic [7:0]       rx_data1_r, rx_data2_r;
    logic             busy_sync1_r, busy_sync2_r;
    logic [7:0]       rx_mem_r [RX_DEPTH];
    logic [7:0]       tx_mem_r [TX_DEPTH];
    logic [RX_AW-1:0] rx_rd_ptr_r, rx_wr_ptr_r;
    logic [TX_AW-1:0] tx_rd_ptr_r, tx_wr_ptr_r;
    logic [RX_AW:0]   rx_count_r, rx_count_next_s;
    logic [TX_AW:0]   tx_count_r, tx_count_next_s;
    logic             rx_overrun_r;
    logic             rx_int_r;
    tx_state_t        state_r, state_next_s;
    logic             tx_start_r, tx_start_next_s;
    logic [7:0]       tx_data_r, tx_data_next_s;

    logic       access_s, data_rd_s, stat_rd_s;
    logic       rx_edge_s, rx_full_s, rx_push_s, rx_pop_s, rx_ovr_set_s;
    logic       tx_full_s, tx_push_s, tx_pop_s;
    logic [7:0] rx_head_s, tx_head_s;

    // Only the first cycle of a held select counts as an access.
    assign access_s  = bus_ce & ~ce_d_r;
    assign data_rd_s = access_s & ~bus_we & (bus_addr == ADDR_DATA);
    assign stat_rd_s = access_s & ~bus_we & (bus_addr == ADDR_STAT);

    assign rx_head_s    = (rx_count_r != '0) ? rx_mem_r[rx_rd_ptr_r] : 8'h00;
    assign tx_head_s    = tx_mem_r[tx_rd_ptr_r];
    assign rx_full_s    = (rx_count_r == RX_FULL);
    assign tx_full_s    = (tx_count_r == TX_FULL);
    assign rx_edge_s    = rx_sync2_r & ~rx_prev_r;
    assign rx_pop_s     = data_rd_s & (rx_count_r != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign rx_push_s    = rx_edge_s & (~rx_full_s | rx_pop_s);
    assign rx_ovr_set_s = rx_edge_s & rx_full_s & ~rx_pop_s;
    assign tx_push_s    = access_s & bus_we & (bus_addr == ADDR_DATA) & ~tx_full_s;

    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign rx_int   = rx_int_r;

    // Synchronisers, access edge detector and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_d_r       <= 1'b0;
            rx_sync1_r   <= 1'b0;
            rx_sync2_r   <= 1'b0;
            rx_prev_r    <= 1'b0;
            rx_data1_r   <= 8'h00;
            rx_data2_r   <= 8'h00;
            busy_sync1_r <= 1'b0;
            busy_sync2_r <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            ce_d_r       <= bus_ce;
            rx_sync1_r   <= rx_ready;
            rx_sync2_r   <= rx_sync1_r;
            rx_prev_r    <= rx_sync2_r;
            rx_data1_r   <= rx_data;
            rx_data2_r   <= rx_data1_r;
            busy_sync1_r <= tx_busy;
            busy_sync2_r <= busy_sync1_r;
            if (rx_ovr_set_s) begin
                rx_overrun_r <= 1'b1;
            end else if (stat_rd_s) begin
                rx_overrun_r <= 1'b0;
            end
        end
    end

    // FIFO storage; validity is tracked solely by the pointers and counts.
    always_ff @(posedge clk) begin
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data2_r;
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= bus_wdata;
    end

    // Next occupancy of both FIFOs.
    always_comb begin
        rx_count_next_s = rx_count_r;
        tx_count_next_s = tx_count_r;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_next_s = rx_count_r + RX_CNT_ONE;
            2'b01:   rx_count_next_s = rx_count_r - RX_CNT_ONE;
            default: rx_count_next_s = rx_count_r;
        endcase
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_next_s = tx_count_r + TX_CNT_ONE;
            2'b01:   tx_count_next_s = tx_count_r - TX_CNT_ONE;
            default: tx_count_next_s = tx_count_r;
        endcase
    end

    // FIFO pointers, counts and the registered interrupt level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rd_ptr_r <= '0;
            rx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_wr_ptr_r <= '0;
            rx_count_r  <= '0;
            tx_count_r  <= '0;
            rx_int_r    <= 1'b0;
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE;
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE;
            rx_count_r <= rx_count_next_s;
            tx_count_r <= tx_count_next_s;
            rx_int_r   <= (rx_count_next_s != '0);
        end
    end

    // Transmit handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            tx_start_r <= tx_start_next_s;
            tx_data_r  <= tx_data_next_s;
        end
    end

    // Transmit handshake next state; the byte leaves the FIFO only once busy is seen.
    always_comb begin
        state_next_s    = state_r;
        tx_start_next_s = tx_start_r;
        tx_data_next_s  = tx_data_r;
        tx_pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_count_r != '0) begin
                    tx_data_next_s  = tx_head_s;
                    tx_start_next_s = 1'b1;
                    state_next_s    = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (busy_sync2_r) begin
                    tx_pop_s        = 1'b1;
                    tx_start_next_s = 1'b0;
                    state_next_s    = ST_WAIT;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_WAIT: begin
                if (!busy_sync2_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                tx_start_next_s = 1'b0;
            end
        endcase
    end

    // Read mux; driven only while a read is selected.
    always_comb begin
        bus_rdata = 32'h0000_0000;
        if (bus_ce && !bus_we) begin
            case (bus_addr)
                ADDR_DATA: bus_rdata = {24'h00_0000, rx_head_s};
                ADDR_STAT: bus_rdata = {29'h0000_0000, rx_overrun_r,
                                        (rx_count_r != '0), ~tx_full_s};
                default:   bus_rdata = 32'h0000_0000;
            endcase
        end else begin
            bus_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Self-checking bench for serial_fifo_ctrl: directed steps plus a randomized phase
// checked against queue-based RX/TX models and a behavioural transmitter.
module tb_serial_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_ce, bus_we;
    logic [3:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_rdata;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rx_int;

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    bit         ovr;
    logic [7:0] tx_seen[$];
    logic [7:0] tx_exp[$];
    bit         tx_en = 1'b0;

    serial_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .bus_ce(bus_ce), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .rx_int(rx_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_we = 1'b0; bus_addr = a; bus_ce = 1'b1;
        #1 d = bus_rdata;
        @(negedge clk); bus_ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d; bus_ce = 1'b1;
        @(negedge clk); bus_ce = 1'b0; bus_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] d, e;
        e = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
        bus_read(4'h8, d);
        chk(tag, d, e);
    endtask

    task automatic read_stat_chk(input string tag, input bit tx_nf);
        logic [31:0] d, e;
        e = {29'h0, ovr, (rxq.size() != 0), tx_nf};
        bus_read(4'hC, d);
        chk(tag, d, e);
        ovr = 1'b0;
    endtask

    // Receiver pulse of w cycles; the model takes the byte once it must have landed.
    task automatic rx_pulse(input logic [7:0] d, input int w);
        rx_data = d; rx_ready = 1'b1;
        repeat (w) @(negedge clk);
        rx_ready = 1'b0; rx_data = 8'($urandom);
        repeat (3) @(negedge clk);
        if (rxq.size() == 16) ovr = 1'b1;
        else rxq.push_back(d);
    endtask

    // Push arriving on the same edge as a data-read pop.
    task automatic rx_push_with_pop(input string tag, input logic [7:0] d);
        logic [31:0] r, e;
        rx_data = d; rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0; rx_data = 8'($urandom);
        @(negedge clk);
        e = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
        bus_read(4'h8, r);
        chk(tag, r, e);
        rxq.push_back(d);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_seen.size() < n && k < budget) begin
            @(negedge clk); k++;
        end
        repeat (40) @(negedge clk);
    endtask

    // Behavioural transmitter: busy rises 2 cycles after start and lasts 20 cycles.
    initial begin
        logic [7:0] d;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en && rst_n === 1'b1 && tx_start === 1'b1) begin
                d = tx_data;
                tx_seen.push_back(d);
                repeat (2) begin
                    @(negedge clk);
                    chk("tx_hold_start", {31'h0, tx_start}, 32'h1);
                    chk("tx_hold_data", {24'h0, tx_data}, {24'h0, d});
                end
                tx_busy = 1'b1;
                repeat (2) @(negedge clk);
                chk("tx_ack_not_yet", {31'h0, tx_start}, 32'h1);
                @(negedge clk);
                chk("tx_ack_drop", {31'h0, tx_start}, 32'h0);
                repeat (17) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b0, b1;
        logic [3:0]  a;
        int          op, ntx;

        rst_n = 1'b0; bus_ce = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 8'h00;
        rx_ready = 1'b0; rx_data = 8'h00; ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("rst_rx_int", {31'h0, rx_int}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        read_stat_chk("reset_status", 1'b1);

        // RX path with latency check on the first byte.
        rx_data = 8'h41; rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
        @(negedge clk);
        chk("rx_int_2edges", {31'h0, rx_int}, 32'h0);
        @(negedge clk);
        chk("rx_int_3edges", {31'h0, rx_int}, 32'h1);
        rxq.push_back(8'h41);
        rx_pulse(8'h42, 2);
        read_data_chk("rx_first");
        read_data_chk("rx_second");
        read_stat_chk("rx_status_empty", 1'b1);
        chk("rx_int_cleared", {31'h0, rx_int}, 32'h0);

        // Overrun: 17 bytes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) rx_pulse(8'(i), 1);
        read_stat_chk("ovr_status", 1'b1);
        read_stat_chk("ovr_cleared", 1'b1);
        for (int i = 0; i < 17; i++) read_data_chk("ovr_drain");

        // Push and pop on the same edge, full then empty.
        for (int i = 0; i < 16; i++) rx_pulse(8'($urandom), 3);
        rx_push_with_pop("full_push_pop", 8'hC3);
        read_stat_chk("full_push_pop_status", 1'b1);
        for (int i = 0; i < 16; i++) read_data_chk("full_push_pop_drain");
        rx_push_with_pop("empty_push_pop", 8'h5A);
        read_data_chk("empty_push_pop_byte");
        read_stat_chk("empty_push_pop_status", 1'b1);

        // Held select produces a single pop.
        b0 = 8'($urandom); b1 = 8'($urandom);
        rx_pulse(b0, 1); rx_pulse(b1, 2);
        bus_we = 1'b0; bus_addr = 4'h8; bus_ce = 1'b1;
        #1 chk("hold_first", bus_rdata, {24'h0, b0});
        repeat (3) begin
            @(negedge clk);
            #1 chk("hold_next", bus_rdata, {24'h0, b1});
        end
        @(negedge clk); bus_ce = 1'b0;
        @(negedge clk);
        void'(rxq.pop_front());
        read_data_chk("hold_remaining");
        read_data_chk("hold_empty");

        // TX handshake with write-to-start latency.
        tx_en = 1'b1; tx_seen.delete();
        bus_we = 1'b1; bus_addr = 4'h8; bus_wdata = 8'h55; bus_ce = 1'b1;
        @(negedge clk); bus_ce = 1'b0; bus_we = 1'b0;
        chk("tx_start_1edge", {31'h0, tx_start}, 32'h0);
        @(negedge clk);
        chk("tx_start_2edges", {31'h0, tx_start}, 32'h1);
        chk("tx_data_first", {24'h0, tx_data}, 32'h55);
        bus_write(4'h8, 8'hAA);
        wait_tx(2, 300);
        chk("tx_count", tx_seen.size(), 2);
        if (tx_seen.size() == 2) begin
            chk("tx_byte0", {24'h0, tx_seen[0]}, 32'h55);
            chk("tx_byte1", {24'h0, tx_seen[1]}, 32'hAA);
        end
        chk("tx_idle", {31'h0, tx_start}, 32'h0);
        read_stat_chk("tx_status", 1'b1);

        // TX full: no acknowledge until 17 writes are done.
        tx_en = 1'b0; tx_seen.delete(); tx_exp.delete();
        for (int i = 0; i < 15; i++) begin
            bus_write(4'h8, 8'(8'h10 + i)); tx_exp.push_back(8'(8'h10 + i));
        end
        read_stat_chk("txfull_15", 1'b1);
        bus_write(4'h8, 8'h1F); tx_exp.push_back(8'h1F);
        read_stat_chk("txfull_16", 1'b0);
        bus_write(4'h8, 8'hEE);
        read_stat_chk("txfull_17", 1'b0);
        chk("txfull_start", {31'h0, tx_start}, 32'h1);
        chk("txfull_head", {24'h0, tx_data}, 32'h10);
        tx_en = 1'b1;
        wait_tx(16, 1500);
        chk("txfull_count", tx_seen.size(), 16);
        for (int i = 0; i < 16 && i < tx_seen.size(); i++)
            chk("txfull_byte", {24'h0, tx_seen[i]}, {24'h0, tx_exp[i]});
        read_stat_chk("txfull_drained", 1'b1);

        // Randomized mix against the models.
        tx_seen.delete(); tx_exp.delete(); ntx = 0;
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: rx_pulse(8'($urandom), $urandom_range(1, 3));
                4, 5: read_data_chk("rand_data");
                6: read_stat_chk("rand_status", 1'b1);
                7: if (ntx < 8) begin
                    b0 = 8'($urandom);
                    bus_write(4'h8, b0); tx_exp.push_back(b0); ntx++;
                end
                8: begin
                    a = 4'($urandom);
                    if (a == 4'h8 || a == 4'hC) a = 4'h0;
                    bus_read(a, r);
                    chk("rand_other_read", r, 32'h0);
                end
                default: begin
                    a = 4'($urandom);
                    if (a == 4'h8) a = 4'hC;
                    bus_write(a, 8'($urandom));
                end
            endcase
        end
        while (rxq.size() != 0) read_data_chk("rand_drain");
        read_stat_chk("rand_final_status", 1'b1);
        wait_tx(tx_exp.size(), 2000);
        chk("rand_tx_count", tx_seen.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
            chk("rand_tx_byte", {24'h0, tx_seen[i]}, {24'h0, tx_exp[i]});

        // Reset abort while a transfer is requested.
        tx_en = 1'b0;
        rx_pulse(8'h61, 1); rx_pulse(8'h62, 1);
        bus_write(4'h8, 8'h77);
        for (int k = 0; k < 10 && tx_start !== 1'b1; k++) @(negedge clk);
        chk("abort_start_before", {31'h0, tx_start}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_start_async", {31'h0, tx_start}, 32'h0);
        chk("abort_rx_int", {31'h0, rx_int}, 32'h0);
        rxq.delete(); ovr = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_start_after", {31'h0, tx_start}, 32'h0);
        read_stat_chk("abort_status", 1'b1);
        read_data_chk("abort_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
